fmc_apb_mailbox: RTL and testbench
==================================

// Module: fmc_apb_mailbox
// PURPOSE
// - APB completer for the free APB2 segment (0xc001_0000) behind the FMC-to-APB bridge and root APBBridge.
// - MCU<->fabric mailbox built from two FIFOs.
//   - TX: firmware writes words over FMC; they drain out as a valid/ready stream to fabric.
//   - RX: fabric pushes words as a valid/ready stream; firmware reads them over FMC.
//   - Status, flush and an RX-not-empty interrupt complete the block.
// PARAMETERS
// - DEPTH       32  entries per FIFO; power of two, 4..256
// - ADDR_WIDTH  16  APB paddr width (matches the root segment)
// PORTS
// - pclk          in   1   APB clock (PLL pclk domain); sole clock
// - preset_n      in   1   asynchronous active-low reset
// - psel          in   1   APB select
// - penable       in   1   APB access phase
// - pwrite        in   1   APB direction
// - paddr         in   16  byte address; [1:0] ignored
// - pwdata        in   32  write data
// - pstrb         in   4   byte strobes
// - pready        out  1   transfer complete
// - prdata        out  32  read data
// - pslverr       out  1   error response
// - tx_valid      out  1   TX stream word available
// - tx_data       out  32  TX stream word (FIFO head)
// - tx_ready      in   1   fabric accepts TX word
// - rx_valid      in   1   fabric offers RX word
// - rx_data       in   32  RX stream word
// - rx_ready      out  1   mailbox accepts RX word
// - irq           out  1   RX-not-empty interrupt, level
// BEHAVIOUR
// - Reset (preset_n low, async): pointers/levels 0, CTRL 0; prdata, pslverr, tx_valid, rx_ready, irq all 0.
// - Registers:
//   - 0x00 TX_DATA  W   push pwdata
//   - 0x04 RX_DATA  R   pop
//   - 0x08 STATUS   R   [8:0] tx_level, [24:16] rx_level, [28] tx_full, [29] tx_empty, [30] rx_full, [31] rx_empty
//   - 0x0c CTRL     RW  [0] tx_flush W1SC, [1] rx_flush W1SC, [2] rx_irq_en; reads [2] only
// - APB timing:
//   - Setup phase (psel & !penable): prdata and pslverr are registered.
//   - Access phase: pready=1 combinationally, so zero wait states.
//   - Push/pop/CTRL update commits on the access cycle edge.
// - pslverr=1 cases; no side effect, prdata=0:
//   - unmapped offset
//   - read of TX_DATA, or write of RX_DATA/STATUS
//   - TX_DATA write with pstrb!=4'hf
//   - TX_DATA write when tx_full; the word is dropped
//   - RX_DATA read when rx_empty; occupancy is sampled at the setup edge
// - TX stream:
//   - First-word-fall-through (FWFT): tx_valid = !tx_empty; tx_data = head.
//   - A push at edge N gives tx_valid=1 after edge N.
//   - Pop on tx_valid & tx_ready.
// - RX stream:
//   - rx_ready = !rx_full, registered; deasserted during reset.
//   - Push on rx_valid & rx_ready; the word is readable at the next APB setup phase.
// - Same-edge push and pop: level unchanged, both pointers advance. Both FIFOs behave this way.
// - Flush:
//   - Pointers and level go to 0 at the CTRL write edge.
//   - Flush beats any same-edge stream push (word discarded) and stream pop (no handshake counted).
//   - tx_valid=0 on the next cycle.
// - Pointers are log2(DEPTH) bits with natural wrap; level is log2(DEPTH)+1 bits, so DEPTH is representable.
// - irq = rx_irq_en & !rx_empty, registered; 1-cycle latency.
// - Async reset mid-transfer aborts the transfer; all contents are lost.
// STRUCTURE
// - Package fmc_mailbox_pkg: register offset localparams, STATUS/CTRL bit-position localparams.
// - Sub-module mailbox_sync_fifo (WIDTH, DEPTH):
//   - LUT-RAM storage, FWFT head, level/full/empty, flush input.
//   - Instantiated once for TX and once for RX.
// - Top holds the APB decode, the error logic, CTRL and irq.
// TESTING
// - Reset: after reset release, STATUS reads 0xa000_0000, tx_valid=0, rx_ready=1 one cycle later, irq=0.
// - TX path:
//   - Write 0x1234_5678, then 0xdead_beef to 0x00, with tx_ready=1.
//   - Stream emits both words in order; tx_valid drops after the second.
// - TX overflow:
//   - With tx_ready=0, write DEPTH words; the next write gets pslverr=1.
//   - STATUS tx_level=DEPTH, tx_full=1; the stream then yields exactly the DEPTH words.
// - RX path:
//   - Set CTRL=0x4; fabric pushes 0xa5a5_0001..0003; irq rises.
//   - Three reads of 0x04 return them in order; the 4th read gets pslverr=1, prdata=0, and irq=0.
// - Wrap and simultaneous: 3*DEPTH words streamed with rx push/APB pop on the same edges.
//   - Data order intact; level never exceeds 1.
// - Flush and errors:
//   - Write CTRL=0x3 while rx_valid=1; both levels read 0.
//   - Writes to 0x08 and 0x10 get pslverr=1.
//   - A TX_DATA write with pstrb=4'h3 gets pslverr=1 and is not pushed.

Source files
------------

// File: rtl/fmc_apb_mailbox_pkg.sv
// Shared constants for the FMC/APB mailbox: register offsets and field positions.
package fmc_mailbox_pkg;

  // Register offsets within the 16-byte page (paddr[3:0] with [1:0] masked)
  localparam logic [3:0] OFF_TX_DATA = 4'h0;
  localparam logic [3:0] OFF_RX_DATA = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;

  // STATUS field positions
  localparam int ST_TX_LEVEL_LSB = 0;
  localparam int ST_RX_LEVEL_LSB = 16;
  localparam int LEVEL_FIELD_W   = 9;
  localparam int ST_TX_FULL      = 28;
  localparam int ST_TX_EMPTY     = 29;
  localparam int ST_RX_FULL      = 30;
  localparam int ST_RX_EMPTY     = 31;

  // CTRL bit positions
  localparam int CTRL_TX_FLUSH   = 0;
  localparam int CTRL_RX_FLUSH   = 1;
  localparam int CTRL_RX_IRQ_EN  = 2;

endpackage

// File: rtl/fmc_apb_mailbox_if.sv
// APB completer bus plus the TX/RX fabric streams of the mailbox.
interface fmc_apb_mailbox_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic                  pready;
  logic [31:0]           prdata;
  logic                  pslverr;
  logic                  tx_valid;
  logic [31:0]           tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [31:0]           rx_data;
  logic                  rx_ready;

  // Mailbox side
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, tx_ready, rx_valid, rx_data,
    output pready, prdata, pslverr, tx_valid, tx_data, rx_ready
  );

  // Bus master / fabric side
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, tx_ready, rx_valid, rx_data,
    input  pready, prdata, pslverr, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/fmc_apb_mailbox_sync_fifo.sv
// Single-clock FIFO with LUT-RAM storage and first-word-fall-through head.
// Flush clears pointers and level and overrides any same-edge push or pop.
module mailbox_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Requests against a full/empty FIFO are ignored rather than corrupting state
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next pointers and level; flush wins over everything, simultaneous push+pop keeps level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fmc_apb_mailbox.sv
// MCU<->fabric mailbox on APB: TX FIFO drained as a stream, RX FIFO filled by a stream,
// with STATUS, CTRL (flush / irq enable) and a level RX-not-empty interrupt.
module fmc_apb_mailbox
  import fmc_mailbox_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic               pclk,
  input  logic               preset_n,
  fmc_apb_mailbox_if.slave   bus,
  output logic               irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             setup, access;
  logic             in_page;
  logic [3:0]       reg_off;
  logic [31:0]      prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;
  logic             xfer_q;
  logic             irq_en_q;
  logic             irq_q;
  logic             rx_ready_q;
  logic             rx_full_d;
  logic [31:0]      status;

  logic             wr_commit, tx_push, ctrl_wr, rx_pop, rx_push_hs;
  logic             tx_flush, rx_flush;

  logic [31:0]      tx_head, rx_head;
  logic [LVL_W-1:0] tx_level, rx_level;
  logic             tx_full, tx_empty, rx_full, rx_empty;

  assign setup   = bus.psel & ~bus.penable;
  assign access  = bus.psel & bus.penable;
  assign in_page = (bus.paddr[ADDR_WIDTH-1:4] == '0);
  assign reg_off = bus.paddr[3:0] & 4'hC;

  assign bus.pready  = access;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;
  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_head;
  assign irq          = irq_q;

  // STATUS word assembled from both FIFOs' occupancy
  always_comb begin
    status = '0;
    status[ST_TX_LEVEL_LSB +: LEVEL_FIELD_W] = LEVEL_FIELD_W'(tx_level);
    status[ST_RX_LEVEL_LSB +: LEVEL_FIELD_W] = LEVEL_FIELD_W'(rx_level);
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
  end

  // Setup-phase decode: error decision and read data, both sampled at the setup edge
  always_comb begin
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (!in_page) begin
      pslverr_d = 1'b1;
    end else begin
      unique case (reg_off)
        OFF_TX_DATA: pslverr_d = ~bus.pwrite | (bus.pstrb != 4'hF) | tx_full;
        OFF_RX_DATA: begin
          if (bus.pwrite || rx_empty) pslverr_d = 1'b1;
          else                        prdata_d  = rx_head;
        end
        OFF_STATUS: begin
          if (bus.pwrite) pslverr_d = 1'b1;
          else            prdata_d  = status;
        end
        OFF_CTRL: begin
          if (!bus.pwrite) prdata_d[CTRL_RX_IRQ_EN] = irq_en_q;
        end
        default: pslverr_d = 1'b1;
      endcase
    end
  end

  // Registered response; xfer_q marks a setup seen since reset so a torn transfer never commits
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      xfer_q    <= 1'b0;
    end else if (setup) begin
      prdata_q  <= pslverr_d ? 32'h0 : prdata_d;
      pslverr_q <= pslverr_d;
      xfer_q    <= 1'b1;
    end else if (access) begin
      xfer_q    <= 1'b0;
    end
  end

  // Side effects commit on the access edge only when the setup decode raised no error
  assign wr_commit = access & xfer_q & ~pslverr_q & bus.pwrite & in_page;
  assign tx_push   = wr_commit & (reg_off == OFF_TX_DATA);
  assign ctrl_wr   = wr_commit & (reg_off == OFF_CTRL) & bus.pstrb[0];
  assign rx_pop    = access & xfer_q & ~pslverr_q & ~bus.pwrite & in_page &
                     (reg_off == OFF_RX_DATA);
  assign tx_flush  = ctrl_wr & bus.pwdata[CTRL_TX_FLUSH];
  assign rx_flush  = ctrl_wr & bus.pwdata[CTRL_RX_FLUSH];
  assign rx_push_hs = bus.rx_valid & rx_ready_q;

  // RX full after this edge, so rx_ready can be registered without overrunning the FIFO
  assign rx_full_d = ~rx_flush &
                     (rx_full ? ~rx_pop
                              : ((rx_level == LVL_W'(DEPTH - 1)) & rx_push_hs & ~rx_pop));

  // CTRL enable bit, registered rx_ready and interrupt
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      irq_en_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= bus.pwdata[CTRL_RX_IRQ_EN];
      rx_ready_q <= ~rx_full_d;
      irq_q      <= irq_en_q & ~rx_empty;
    end
  end

  mailbox_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk         (pclk),
    .rst_n       (preset_n),
    .push_i      (tx_push),
    .push_data_i (bus.pwdata),
    .pop_i       (bus.tx_ready & ~tx_empty),
    .flush_i     (tx_flush),
    .head_o      (tx_head),
    .level_o     (tx_level),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  mailbox_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk         (pclk),
    .rst_n       (preset_n),
    .push_i      (rx_push_hs),
    .push_data_i (bus.rx_data),
    .pop_i       (rx_pop),
    .flush_i     (rx_flush),
    .head_o      (rx_head),
    .level_o     (rx_level),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

endmodule

// File: tb/tb_fmc_apb_mailbox.sv
// Directed bench for fmc_apb_mailbox: vector table for register traffic plus
// hand-written sequences for the stream, overflow, wrap and flush cases.
module tb_fmc_apb_mailbox;

  localparam int DEPTH = 32;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic irq;

  always #5 pclk = ~pclk;

  fmc_apb_mailbox_if #(.ADDR_WIDTH(16)) bus ();

  fmc_apb_mailbox #(.DEPTH(DEPTH), .ADDR_WIDTH(16)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus),
    .irq      (irq)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_rdata;
  } vec_t;

  vec_t vecs[17];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] tx_got[$];

  // Record every TX stream handshake
  always @(posedge pclk) begin
    if (preset_n && bus.tx_valid && bus.tx_ready) tx_got.push_back(bus.tx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] er, input logic ee,
                              input logic cr);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st;
    v.exp_rdata = er; v.exp_err = ee; v.chk_rdata = cr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // One APB transfer; optionally offers an RX stream word during the access cycle only
  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic rxv, input logic [31:0] rxd,
                     output logic [31:0] rdata, output logic err);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    if (rxv) begin bus.rx_valid = 1'b1; bus.rx_data = rxd; end
    @(negedge pclk);
    check("pready", 32'(bus.pready), 32'd1);
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (rxv) bus.rx_valid = 1'b0;
    $display("apb %s addr=0x%04h wdata=0x%08h strb=%h rdata=0x%08h err=%0d",
             wr ? "WR" : "RD", addr, wdata, strb, rdata, err);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [31:0] rd;
    logic        er;
    for (int i = lo; i <= hi; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b0, 32'h0, rd, er);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
  endtask

  task automatic rx_push(input logic [31:0] d);
    @(posedge pclk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = d;
    @(negedge pclk);
    check("rx_ready_push", 32'(bus.rx_ready), 32'd1);
    @(posedge pclk); #1;
    bus.rx_valid = 1'b0;
    $display("rx push 0x%08h", d);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          max_lvl;

    vecs[0]  = mk(1'b0, 16'h0008, 32'h0,         4'hF, 32'hA000_0000, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 16'h000C, 32'h4,         4'hF, 32'h0,         1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 16'h000C, 32'h0,         4'hF, 32'h0000_0004, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 16'h0004, 32'h0,         4'hF, 32'hA5A5_0001, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 16'h0004, 32'h0,         4'hF, 32'hA5A5_0002, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 16'h0004, 32'h0,         4'hF, 32'hA5A5_0003, 1'b0, 1'b1);
    vecs[6]  = mk(1'b0, 16'h0004, 32'h0,         4'hF, 32'h0,         1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 16'h0008, 32'h0,         4'hF, 32'hA000_0004 & 32'hA000_0000, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 16'h0008, 32'h0,         4'hF, 32'hA000_0000, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 16'h0008, 32'h1,         4'hF, 32'h0,         1'b1, 1'b0);
    vecs[10] = mk(1'b1, 16'h0010, 32'h1,         4'hF, 32'h0,         1'b1, 1'b0);
    vecs[11] = mk(1'b1, 16'h0000, 32'hBBBB_BBBB, 4'h3, 32'h0,         1'b1, 1'b0);
    vecs[12] = mk(1'b0, 16'h0008, 32'h0,         4'hF, 32'hA000_0000, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 16'h0000, 32'h0,         4'hF, 32'h0,         1'b1, 1'b1);
    vecs[14] = mk(1'b0, 16'h0010, 32'h0,         4'hF, 32'h0,         1'b1, 1'b1);
    vecs[15] = mk(1'b0, 16'h000C, 32'h0,         4'hF, 32'h0,         1'b0, 1'b1);
    vecs[16] = mk(1'b1, 16'h0004, 32'h1,         4'hF, 32'h0,         1'b1, 1'b0);

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = '0; bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;

    // Reset values
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_irq",      32'(irq),          32'd0);
    check("rst_prdata",   bus.prdata,        32'h0);
    check("rst_pslverr",  32'(bus.pslverr),  32'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    check("rel_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rel_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rel_irq",      32'(irq),          32'd0);
    run_vecs(0, 0);

    // TX path
    bus.tx_ready = 1'b1;
    tx_got.delete();
    apb(1'b1, 16'h0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0, rd, er);
    check("tx1_err", 32'(er), 32'd0);
    apb(1'b1, 16'h0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, rd, er);
    check("tx2_err", 32'(er), 32'd0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("tx_count", 32'(tx_got.size()), 32'd2);
    check("tx_word0", (tx_got.size() > 0) ? tx_got[0] : 32'hx, 32'h1234_5678);
    check("tx_word1", (tx_got.size() > 1) ? tx_got[1] : 32'hx, 32'hDEAD_BEEF);
    check("tx_valid_drop", 32'(bus.tx_valid), 32'd0);

    // TX overflow
    @(posedge pclk); #1;
    bus.tx_ready = 1'b0;
    tx_got.delete();
    for (int i = 0; i < DEPTH; i++) begin
      apb(1'b1, 16'h0000, 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, 32'h0, rd, er);
      check($sformatf("ovf_fill%0d_err", i), 32'(er), 32'd0);
    end
    apb(1'b1, 16'h0000, 32'hBADB_AD00, 4'hF, 1'b0, 32'h0, rd, er);
    check("ovf_extra_err", 32'(er), 32'd1);
    apb(1'b0, 16'h0008, 32'h0, 4'hF, 1'b0, 32'h0, rd, er);
    check("ovf_status", rd, 32'h9000_0020);
    @(negedge pclk);
    check("ovf_tx_valid", 32'(bus.tx_valid), 32'd1);
    @(posedge pclk); #1;
    bus.tx_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge pclk);
    @(negedge pclk);
    check("ovf_drain_count", 32'(tx_got.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("ovf_word%0d", i), (tx_got.size() > i) ? tx_got[i] : 32'hx,
            32'hC0DE_0000 + 32'(i));
    check("ovf_tx_valid_end", 32'(bus.tx_valid), 32'd0);

    // RX path with interrupt
    run_vecs(1, 2);
    @(negedge pclk);
    check("irq_empty", 32'(irq), 32'd0);
    rx_push(32'hA5A5_0001);
    rx_push(32'hA5A5_0002);
    rx_push(32'hA5A5_0003);
    @(negedge pclk);
    check("irq_rise", 32'(irq), 32'd1);
    run_vecs(3, 6);
    @(negedge pclk);
    check("irq_fall", 32'(irq), 32'd0);
    run_vecs(7, 7);

    // Wrap with same-edge RX push and APB pop
    max_lvl = 0;
    rx_push(32'h5000_0000);
    for (int k = 1; k < 3 * DEPTH; k++) begin
      apb(1'b0, 16'h0004, 32'h0, 4'hF, 1'b1, 32'h5000_0000 + 32'(k), rd, er);
      check($sformatf("wrap%0d_data", k), rd, 32'h5000_0000 + 32'(k - 1));
      check($sformatf("wrap%0d_err", k), 32'(er), 32'd0);
      apb(1'b0, 16'h0008, 32'h0, 4'hF, 1'b0, 32'h0, rd, er);
      if (int'(rd[24:16]) > max_lvl) max_lvl = int'(rd[24:16]);
    end
    apb(1'b0, 16'h0004, 32'h0, 4'hF, 1'b0, 32'h0, rd, er);
    check("wrap_last_data", rd, 32'h5000_0000 + 32'(3 * DEPTH - 1));
    check("wrap_max_level", 32'(max_lvl), 32'd1);

    // Flush both FIFOs while the fabric keeps offering RX words
    @(posedge pclk); #1;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      apb(1'b1, 16'h0000, 32'hF000_0000 + 32'(i), 4'hF, 1'b0, 32'h0, rd, er);
    rx_push(32'hE000_0000);
    rx_push(32'hE000_0001);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 32'h7777_7777;
    apb(1'b1, 16'h000C, 32'h3, 4'hF, 1'b0, 32'h0, rd, er);
    bus.rx_valid = 1'b0;
    check("flush_err", 32'(er), 32'd0);
    @(negedge pclk);
    check("flush_tx_valid", 32'(bus.tx_valid), 32'd0);
    run_vecs(8, 16);
    @(negedge pclk);
    check("strb_tx_valid", 32'(bus.tx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
